checker_ctlif_mc: RTL and testbench
===================================

// Module: checker_ctlif_mc
// PURPOSE
//  Multi-channel CSR control interface for the checker core; successor to single-channel ctlif.
//  Holds NCHAN independent checker jobs (64-bit address, mode, start), tracks each job through run/end.
//  Captures cctrl result and run-cycle count per job; aggregates per-channel completion into one irq.
//  Sits between the CSR bus and NCHAN checker engines.
// PARAMETERS
//  CSR_ADDR   4'h0   bank select, matched against csr_a[13:10]
//  NCHAN      4      channel count, 1..16
//  TIMEOUT    0      run-cycle limit per job; 0 = watchdog disabled
// PORTS
//  sys_clk  in   1         clock, all logic on rising edge
//  sys_rst  in   1         synchronous, active-high reset
//  csr_a    in   14        CSR address; [13:10] bank, [9:0] register index
//  csr_we   in   1         CSR write strobe, single cycle
//  csr_di   in   32        CSR write data
//  csr_do   out  32        CSR read data, registered
//  irq      out  1         level interrupt, registered
//  cmode    out  2*NCHAN   per-channel mode, ch i at [2i+1:2i]
//  cstart   out  NCHAN     per-channel run request, high for whole job
//  caddr    out  64*NCHAN  per-channel target address
//  cend     in   NCHAN     per-channel completion pulse from engine
//  cctrl    in   8*NCHAN   per-channel result byte, valid with cend
// BEHAVIOUR
//  Reset: csr_do=0, irq=0, cstart=0, cmode=0, caddr=0; all regs, counters, pending, enable = 0; FSMs IDLE.
//  Map (bank hit only): 0x000 IRQ_PEND (W1C), 0x001 IRQ_EN, 0x002 INFO RO {16'NCHAN,16'TIMEOUT[15:0]}.
//   ch i base 0x010+4i: +0 ADDR_LOW, +1 ADDR_HIGH, +2 CTRL, +3 STAT RO.
//  CTRL: bit0 ie, bits2:1 mode, bit3 start. Read: {28'0, running, mode, ie}.
//  STAT: {cycles[23:0], cctrl_q}; extended cycles read at +3 not provided; STAT.bit order fixed as above.
//  Read latency 1 cycle: csr_do updates the clock after csr_a; 0 on bank miss or unmapped index.
//  Channel FSM (per channel, IDLE/RUN):
//   IDLE->RUN: write CTRL with start=1; cstart=1 from next cycle; cycle count cleared to 0.
//   RUN: count +1 per cycle, saturates at 2^32-1; ADDR_LOW/HIGH and CTRL.mode/ie writes ignored.
//   RUN->IDLE on cend[i]: latch cctrl[i], result code DONE; cstart=0 next cycle.
//   RUN->IDLE on CTRL write start=0: user abort, code ABORT, cctrl_q unchanged.
//   RUN->IDLE when TIMEOUT!=0 and count==TIMEOUT-1: code TIMEOUT.
//   Every RUN->IDLE sets IRQ_PEND[i]; cend in IDLE ignored (no pend, no latch).
//  Simultaneous: cend beats abort write and timeout same cycle (code DONE);
//   pend set beats W1C same cycle; start=1 write while RUN has no effect.
//  Result code held in cctrl_q slot only for DONE; ABORT/TIMEOUT visible via IRQ_PEND + STAT cycles.
//  irq = |(IRQ_PEND & IRQ_EN & ie_vector), registered: asserts 1 cycle after pend set.
//  Reset mid-job: cstart drops at next edge, pend cleared, no irq.
// STRUCTURE
//  checker.vh: CSR offsets, CTRL bit positions, CHECKER_MODE_* codes, result codes DONE/ABORT/TIMEOUT.
//  Sub-module checker_ctlif_chan: one channel's regs, FSM, cycle counter, cctrl latch;
//   generate-instantiated NCHAN times. Top holds decode, IRQ_PEND/EN, csr_do mux, irq.
// TESTING
//  1 write ch0 ADDR_LOW=0xaaaaaaaa, ADDR_HIGH=0xbbbbbbbb -> caddr[63:0]=0xbbbbbbbbaaaaaaaa; readback 1 cycle later.
//  2 IRQ_EN=1, ch0 CTRL=0xB (ie,mode=DUMMY,start); 10 cycles; cend[0] with cctrl=0x5A -> cstart[0]=0 next cycle,
//    STAT={24'd10 +/-1 per spec timing,8'h5A}, IRQ_PEND=1, irq=1; W1C 1 -> irq=0.
//  3 ch0 running, write CTRL start=0 -> cstart[0]=0, CTRL read bit3=0, IRQ_PEND[0]=1.
//  4 TIMEOUT=8: start ch1, no cend -> cstart[1] drops after 8 cycles, IRQ_PEND[1]=1; cend same cycle wins.
//  5 ch2 running, write ADDR_LOW=0x1 -> caddr unchanged; start ch2 again -> no restart; cend in IDLE -> no pend.
//  6 sys_rst mid-job on ch0,ch3 -> all outputs 0 next edge; csr_a with bank 4'hF -> csr_do=0.

Source files
------------

// File: rtl/checker_ctlif_mc_pkg.sv
// Shared definitions for the multi-channel checker control interface:
// register offsets, CTRL bit positions, checker modes and job result codes.
package checker_ctlif_mc_pkg;

  localparam logic [9:0] REG_IRQ_PEND = 10'h000;
  localparam logic [9:0] REG_IRQ_EN   = 10'h001;
  localparam logic [9:0] REG_INFO     = 10'h002;
  localparam logic [9:0] CH_BASE      = 10'h010;

  localparam logic [1:0] CH_ADDR_LOW  = 2'd0;
  localparam logic [1:0] CH_ADDR_HIGH = 2'd1;
  localparam logic [1:0] CH_CTRL      = 2'd2;
  localparam logic [1:0] CH_STAT      = 2'd3;

  localparam int CTRL_IE      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_START   = 3;

  typedef enum logic [1:0] {
    CHECKER_MODE_READ  = 2'd0,
    CHECKER_MODE_DUMMY = 2'd1,
    CHECKER_MODE_WRITE = 2'd2,
    CHECKER_MODE_CHECK = 2'd3
  } checker_mode_e;

  typedef enum logic [1:0] {
    RES_DONE    = 2'd0,
    RES_ABORT   = 2'd1,
    RES_TIMEOUT = 2'd2
  } res_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/checker_ctlif_mc_if.sv
// CSR bus between the host and the checker control interface.
interface checker_ctlif_mc_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/checker_ctlif_mc_chan.sv
// One checker channel: job registers, IDLE/RUN FSM, saturating run-cycle
// counter and the result-byte latch.
module checker_ctlif_mc_chan
  import checker_ctlif_mc_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic        we_ctrl,
  input  logic [31:0] wdata,
  input  logic [1:0]  rsel,
  input  logic        cend,
  input  logic [7:0]  cctrl,
  output logic [63:0] caddr,
  output logic [1:0]  cmode,
  output logic        cstart,
  output logic        ie,
  output logic        fin,
  output logic [31:0] rdata
);

  chan_state_e   state, state_nx;
  checker_mode_e mode_q;
  res_e          code;
  logic [31:0]   cycles;
  logic [7:0]    cctrl_q;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cycles == 32'(TIMEOUT - 1));
  assign cstart      = (state == ST_RUN);
  assign cmode       = mode_q;

  // Completion beats abort, abort beats timeout when they coincide.
  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    code     = RES_DONE;
    if (state == ST_IDLE) begin
      if (we_ctrl && wdata[CTRL_START]) state_nx = ST_RUN;
    end else begin
      if (cend) begin
        code = RES_DONE;
        fin  = 1'b1;
      end else if (we_ctrl && !wdata[CTRL_START]) begin
        code = RES_ABORT;
        fin  = 1'b1;
      end else if (timeout_hit) begin
        code = RES_TIMEOUT;
        fin  = 1'b1;
      end
      if (fin) state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= CHECKER_MODE_READ;
      ie      <= 1'b0;
      caddr   <= '0;
      cycles  <= '0;
      cctrl_q <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) begin
        if (we_lo) caddr[31:0]  <= wdata;
        if (we_hi) caddr[63:32] <= wdata;
        if (we_ctrl) begin
          ie     <= wdata[CTRL_IE];
          mode_q <= checker_mode_e'(wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
        end
        if (state_nx == ST_RUN) cycles <= '0;
      end else begin
        cycles <= (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
        if (fin && code == RES_DONE) cctrl_q <= cctrl;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      CH_ADDR_LOW:  rdata = caddr[31:0];
      CH_ADDR_HIGH: rdata = caddr[63:32];
      CH_CTRL:      rdata = {28'd0, cstart, cmode, ie};
      CH_STAT:      rdata = {cycles[23:0], cctrl_q};
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/checker_ctlif_mc.sv
// Multi-channel CSR control interface for the checker core: address decode,
// shared IRQ pending/enable registers, registered read mux and irq.
module checker_ctlif_mc
  import checker_ctlif_mc_pkg::*;
#(
  parameter logic [3:0] CSR_ADDR = 4'h0,
  parameter int         NCHAN    = 4,
  parameter int         TIMEOUT  = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  checker_ctlif_mc_if.slave     csr,
  output logic                  irq,
  output logic [2*NCHAN-1:0]    cmode,
  output logic [NCHAN-1:0]      cstart,
  output logic [64*NCHAN-1:0]   caddr,
  input  logic [NCHAN-1:0]      cend,
  input  logic [8*NCHAN-1:0]    cctrl
);

  localparam logic [31:0] INFO_WORD = {16'(NCHAN), 16'(TIMEOUT)};

  logic [9:0]       idx;
  logic             bank_hit, ch_hit;
  logic [7:0]       chsel;
  logic [1:0]       creg;
  logic [NCHAN-1:0] pend, en, w1c, fin_vec, ie_vec;
  logic [31:0]      ch_rd [NCHAN];
  logic [31:0]      rdata;

  assign idx      = csr.csr_a[9:0];
  assign bank_hit = (csr.csr_a[13:10] == CSR_ADDR);
  assign chsel    = idx[9:2] - CH_BASE[9:2];
  assign creg     = idx[1:0];
  assign ch_hit   = bank_hit && (idx >= CH_BASE) && (idx < 10'(CH_BASE + 4 * NCHAN));
  assign w1c      = (csr.csr_we && bank_hit && idx == REG_IRQ_PEND) ? csr.csr_di[NCHAN-1:0] : '0;

  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    logic sel;
    assign sel = ch_hit && (chsel == 8'(i));

    checker_ctlif_mc_chan #(.TIMEOUT(TIMEOUT)) u_chan (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .we_lo   (csr.csr_we && sel && creg == CH_ADDR_LOW),
      .we_hi   (csr.csr_we && sel && creg == CH_ADDR_HIGH),
      .we_ctrl (csr.csr_we && sel && creg == CH_CTRL),
      .wdata   (csr.csr_di),
      .rsel    (creg),
      .cend    (cend[i]),
      .cctrl   (cctrl[8*i +: 8]),
      .caddr   (caddr[64*i +: 64]),
      .cmode   (cmode[2*i +: 2]),
      .cstart  (cstart[i]),
      .ie      (ie_vec[i]),
      .fin     (fin_vec[i]),
      .rdata   (ch_rd[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (bank_hit) begin
      case (idx)
        REG_IRQ_PEND: rdata = 32'(pend);
        REG_IRQ_EN:   rdata = 32'(en);
        REG_INFO:     rdata = INFO_WORD;
        default: begin
          for (int i = 0; i < NCHAN; i++) begin
            if (ch_hit && chsel == 8'(i)) rdata = ch_rd[i];
          end
        end
      endcase
    end
  end

  // A job ending in the same cycle as a W1C of its bit keeps the bit set.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend       <= '0;
      en         <= '0;
      irq        <= 1'b0;
      csr.csr_do <= '0;
    end else begin
      pend <= (pend & ~w1c) | fin_vec;
      if (csr.csr_we && bank_hit && idx == REG_IRQ_EN) en <= csr.csr_di[NCHAN-1:0];
      irq        <= |(pend & en & ie_vec);
      csr.csr_do <= rdata;
    end
  end

endmodule

// File: tb/tb_checker_ctlif_mc.sv
// Bench for checker_ctlif_mc: two instances (watchdog off / TIMEOUT=8) share
// one stimulus stream and are compared every cycle against a job-level model.
module tb_checker_ctlif_mc;
  localparam int TO1 = 8;

  logic        clk, rst, we;
  logic [13:0] a;
  logic [31:0] di;
  logic [3:0]  cend_v;
  logic [31:0] cctrl_v;

  logic         irq0, irq1;
  logic [7:0]   cmode0, cmode1;
  logic [3:0]   cstart0, cstart1;
  logic [255:0] caddr0, caddr1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  checker_ctlif_mc_if bus0 ();
  checker_ctlif_mc_if bus1 ();
  assign bus0.csr_a = a;  assign bus0.csr_we = we;  assign bus0.csr_di = di;
  assign bus1.csr_a = a;  assign bus1.csr_we = we;  assign bus1.csr_di = di;

  checker_ctlif_mc #(.CSR_ADDR(4'h0), .NCHAN(4), .TIMEOUT(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .csr(bus0), .irq(irq0), .cmode(cmode0),
    .cstart(cstart0), .caddr(caddr0), .cend(cend_v), .cctrl(cctrl_v));
  checker_ctlif_mc #(.CSR_ADDR(4'h0), .NCHAN(4), .TIMEOUT(TO1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .csr(bus1), .irq(irq1), .cmode(cmode1),
    .cstart(cstart1), .caddr(caddr1), .cend(cend_v), .cctrl(cctrl_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Job-level model, one copy per instance.
  bit          m_run  [2][4];
  logic [31:0] m_cyc  [2][4];
  logic [63:0] m_addr [2][4];
  logic [1:0]  m_mode [2][4];
  bit          m_ie   [2][4];
  logic [7:0]  m_cq   [2][4];
  logic [3:0]  m_pend [2];
  logic [3:0]  m_en   [2];
  bit          m_irq  [2];
  logic [31:0] m_do   [2];

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] mread(int d, logic [13:0] adr);
    int idx, ch, off;
    idx = int'(adr[9:0]);
    if (adr[13:10] != 4'h0) return 32'h0;
    if (idx == 0) return {28'd0, m_pend[d]};
    if (idx == 1) return {28'd0, m_en[d]};
    if (idx == 2) return {16'd4, (d == 1) ? 16'(TO1) : 16'd0};
    if (idx >= 16 && idx < 32) begin
      ch  = (idx - 16) / 4;
      off = (idx - 16) % 4;
      case (off)
        0: return m_addr[d][ch][31:0];
        1: return m_addr[d][ch][63:32];
        2: return {28'd0, m_run[d][ch], m_mode[d][ch], m_ie[d][ch]};
        default: return {m_cyc[d][ch][23:0], m_cq[d][ch]};
      endcase
    end
    return 32'h0;
  endfunction

  task automatic mstep(int d);
    logic [3:0] fin, iev;
    int idx, tov, base;
    bit hit, wctl;
    tov = (d == 1) ? TO1 : 0;
    idx = int'(a[9:0]);
    hit = (a[13:10] == 4'h0);
    fin = '0;
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_run[d][ch] = 0; m_cyc[d][ch] = '0; m_addr[d][ch] = '0;
        m_mode[d][ch] = '0; m_ie[d][ch] = 0; m_cq[d][ch] = '0;
      end
      m_pend[d] = '0; m_en[d] = '0; m_irq[d] = 0; m_do[d] = '0;
      return;
    end
    for (int ch = 0; ch < 4; ch++) iev[ch] = m_ie[d][ch];
    m_irq[d] = |(m_pend[d] & m_en[d] & iev);
    m_do[d]  = mread(d, a);
    for (int ch = 0; ch < 4; ch++) begin
      base = 16 + 4 * ch;
      wctl = we && hit && (idx == base + 2);
      if (m_run[d][ch]) begin
        if (cend_v[ch]) begin
          fin[ch] = 1'b1;
          m_cq[d][ch] = cctrl_v[8*ch +: 8];
        end else if (wctl && !di[3]) fin[ch] = 1'b1;
        else if (tov != 0 && m_cyc[d][ch] == 32'(tov - 1)) fin[ch] = 1'b1;
        if (m_cyc[d][ch] != 32'hFFFF_FFFF) m_cyc[d][ch] = m_cyc[d][ch] + 1;
        if (fin[ch]) m_run[d][ch] = 0;
      end else begin
        if (we && hit && idx == base)     m_addr[d][ch][31:0]  = di;
        if (we && hit && idx == base + 1) m_addr[d][ch][63:32] = di;
        if (wctl) begin
          m_ie[d][ch]   = di[0];
          m_mode[d][ch] = di[2:1];
          if (di[3]) begin
            m_run[d][ch] = 1;
            m_cyc[d][ch] = '0;
          end
        end
      end
    end
    if (we && hit && idx == 0) m_pend[d] = m_pend[d] & ~di[3:0];
    m_pend[d] = m_pend[d] | fin;
    if (we && hit && idx == 1) m_en[d] = di[3:0];
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  task automatic cmp_dut(int d, logic [31:0] dov, logic irqv, logic [3:0] csv,
                         logic [7:0] cmv, logic [255:0] cav);
    logic [3:0]   xs;
    logic [7:0]   xm;
    logic [255:0] xa;
    for (int ch = 0; ch < 4; ch++) begin
      xs[ch] = m_run[d][ch];
      xm[2*ch +: 2] = m_mode[d][ch];
      xa[64*ch +: 64] = m_addr[d][ch];
    end
    chk($sformatf("d%0d.csr_do", d), 256'(dov), 256'(m_do[d]));
    chk($sformatf("d%0d.irq", d), 256'(irqv), 256'(m_irq[d]));
    chk($sformatf("d%0d.cstart", d), 256'(csv), 256'(xs));
    chk($sformatf("d%0d.cmode", d), 256'(cmv), 256'(xm));
    chk($sformatf("d%0d.caddr", d), cav, xa);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut(0, bus0.csr_do, irq0, cstart0, cmode0, caddr0);
      cmp_dut(1, bus1.csr_do, irq1, cstart1, cmode1, caddr1);
    end
  end

  task automatic csr_wr(logic [13:0] adr, logic [31:0] dat);
    a = adr; we = 1'b1; di = dat;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    int cnt, r, ch;
    rst = 1'b1; we = 1'b0; a = '0; di = '0; cend_v = '0; cctrl_v = '0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("reset csr_do", 256'(bus0.csr_do), 256'h0);
    chk("reset irq", 256'(irq0), 256'h0);
    chk("reset cstart", 256'({cstart1, cstart0}), 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Address registers and readback.
    csr_wr(14'h010, 32'haaaa_aaaa);
    csr_wr(14'h011, 32'hbbbb_bbbb);
    chk("t1 caddr0", 256'(caddr0[63:0]), 256'h0000_0000_0000_0000_bbbb_bbbb_aaaa_aaaa);
    a = 14'h010;
    @(negedge clk);
    chk("t1 rd addr_low", 256'(bus0.csr_do), 256'haaaa_aaaa);

    // Completed job: STAT, pend, irq, W1C.
    csr_wr(14'h001, 32'h1);
    csr_wr(14'h012, 32'hB);
    chk("t2 cstart on", 256'(cstart0[0]), 256'h1);
    chk("t2 cmode", 256'(cmode0[1:0]), 256'h1);
    repeat (9) @(negedge clk);
    cend_v = 4'b0001; cctrl_v = 32'h5A;
    @(negedge clk);
    cend_v = '0;
    chk("t2 cstart off", 256'(cstart0[0]), 256'h0);
    a = 14'h013;
    @(negedge clk);
    chk("t2 stat", 256'(bus0.csr_do), 256'h0000_0A5A);
    chk("t2 irq", 256'(irq0), 256'h1);
    a = 14'h000;
    @(negedge clk);
    chk("t2 pend", 256'(bus0.csr_do), 256'h1);
    csr_wr(14'h000, 32'h1);
    @(negedge clk);
    chk("t2 irq cleared", 256'(irq0), 256'h0);

    // User abort.
    csr_wr(14'h012, 32'hB);
    repeat (3) @(negedge clk);
    csr_wr(14'h012, 32'h2);
    chk("t3 cstart off", 256'(cstart0[0]), 256'h0);
    a = 14'h012;
    @(negedge clk);
    chk("t3 ctrl rd", 256'(bus0.csr_do), 256'h3);
    a = 14'h000;
    @(negedge clk);
    chk("t3 pend", 256'(bus0.csr_do), 256'h1);
    csr_wr(14'h000, 32'hF);

    // Watchdog on the TIMEOUT=8 instance, then cend on the timeout cycle.
    csr_wr(14'h016, 32'h8);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cstart1[1]) break;
      cnt++;
      @(negedge clk);
    end
    chk("t4 run cycles", 256'(cnt), 256'd8);
    a = 14'h017;
    @(negedge clk);
    chk("t4 stat timeout", 256'(bus1.csr_do), 256'h0000_0800);
    a = 14'h000;
    @(negedge clk);
    chk("t4 pend", 256'(bus1.csr_do), 256'h2);
    csr_wr(14'h016, 32'h8);
    repeat (7) @(negedge clk);
    cend_v = 4'b0010; cctrl_v = 32'h0000_7700;
    @(negedge clk);
    cend_v = '0;
    chk("t4 cstart off", 256'(cstart1[1]), 256'h0);
    a = 14'h017;
    @(negedge clk);
    chk("t4 cend wins", 256'(bus1.csr_do), 256'h0000_0877);

    // Writes ignored while running, no restart, cend in IDLE ignored.
    csr_wr(14'h000, 32'hF);
    csr_wr(14'h01A, 32'h8);
    csr_wr(14'h018, 32'h1);
    csr_wr(14'h01A, 32'h8);
    chk("t5 caddr2", 256'(caddr0[191:128]), 256'h0);
    chk("t5 still running", 256'(cstart0[2]), 256'h1);
    a = 14'h01B;
    @(negedge clk);
    chk("t5 no restart", 256'(bus0.csr_do), 256'h0000_0200);
    csr_wr(14'h01A, 32'h0);
    csr_wr(14'h000, 32'hF);
    cend_v = 4'b0100; cctrl_v = 32'h00AB_0000;
    @(negedge clk);
    cend_v = '0;
    a = 14'h000;
    @(negedge clk);
    chk("t5 idle cend pend", 256'(bus0.csr_do), 256'h0);
    a = 14'h01B;
    @(negedge clk);
    chk("t5 idle cend stat", 256'(bus0.csr_do), 256'h0000_0400);

    // Reset mid-job, bank miss, INFO.
    csr_wr(14'h012, 32'h8);
    csr_wr(14'h01E, 32'h8);
    csr_wr(14'h001, 32'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 cstart", 256'({cstart1, cstart0}), 256'h0);
    chk("t6 cmode", 256'({cmode1, cmode0}), 256'h0);
    chk("t6 caddr", caddr0 | caddr1, 256'h0);
    chk("t6 irq", 256'({irq1, irq0}), 256'h0);
    chk("t6 csr_do", 256'(bus0.csr_do), 256'h0);
    csr_wr(14'h001, 32'hF);
    a = {4'hF, 10'h001};
    @(negedge clk);
    chk("t6 bank miss", 256'(bus0.csr_do), 256'h0);
    a = 14'h001;
    @(negedge clk);
    chk("t6 bank hit", 256'(bus0.csr_do), 256'hF);
    a = 14'h002;
    @(negedge clk);
    chk("t6 info0", 256'(bus0.csr_do), 256'h0004_0000);
    chk("t6 info1", 256'(bus1.csr_do), 256'h0004_0008);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      we = ($urandom_range(0, 2) == 0);
      di = $urandom;
      case (r)
        0: a = 14'h000;
        1: a = 14'h001;
        2: a = 14'h002;
        8: a = {4'hF, 10'($urandom_range(0, 31))};
        9: a = 14'($urandom_range(0, 127));
        default: begin
          a = 14'(16 + 4 * ch + $urandom_range(0, 3));
          if (a[1:0] == 2'd2) di = 32'($urandom_range(0, 15));
        end
      endcase
      for (int k = 0; k < 4; k++) cend_v[k] = ($urandom_range(0, 11) == 0);
      cctrl_v = $urandom;
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; we = 1'b0; cend_v = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
